// File: rtl/vga_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axil_slave (with vga_axil_pkg)
//  Brief    : AXI4-Lite slave that serialises reads/writes into single
//             word-addressed native register accesses for the VGA block.
//  Revision : 1.0 - initial release
// ============================================================================

package vga_axil_pkg;
    localparam int AXIL_ADDR_W   = 32;
    localparam int AXIL_DATA_W   = 32;
    localparam int AXIL_RESP_W   = 2;
    localparam int AXIL_STRB_W   = AXIL_DATA_W / 8;
    localparam int NATIVE_ADDR_W = 30;

    typedef logic [AXIL_ADDR_W-1:0]   axil_addr_t;
    typedef logic [AXIL_DATA_W-1:0]   axil_data_t;
    typedef logic [AXIL_RESP_W-1:0]   axil_resp_t;
    typedef logic [AXIL_STRB_W-1:0]   axil_strb_t;
    typedef logic [NATIVE_ADDR_W-1:0] native_addr_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_SLVERR = 2'b10;

    // Byte address to 32-bit word address.
    function automatic native_addr_t axil2native_addr(input axil_addr_t addr);
        return native_addr_t'(addr >> 2);
    endfunction
endpackage

module vga_axil_slave
    import vga_axil_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    // write address
    input  logic         awvalid_i,
    output logic         awready_o,
    input  axil_addr_t   awaddr_i,
    // write data
    input  logic         wvalid_i,
    output logic         wready_o,
    input  axil_data_t   wdata_i,
    input  axil_strb_t   wstrb_i,
    // write response
    output logic         bvalid_o,
    input  logic         bready_i,
    output axil_resp_t   bresp_o,
    // read address
    input  logic         arvalid_i,
    output logic         arready_o,
    input  axil_addr_t   araddr_i,
    // read data
    output logic         rvalid_o,
    input  logic         rready_i,
    output axil_data_t   rdata_o,
    output axil_resp_t   rresp_o,
    // native register port
    output logic         native_req_o,
    output logic         native_we_o,
    output native_addr_t native_addr_o,
    output axil_data_t   native_wdata_o,
    output axil_strb_t   native_be_o,
    input  logic         native_gnt_i,
    input  logic         native_rvalid_i,
    input  axil_data_t   native_rdata_i,
    input  logic         native_err_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NREQ  = 3'd1,
        S_NWAIT = 3'd2,
        S_BRESP = 3'd3,
        S_RRESP = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic         r_ready_en;
    logic         r_prio_rd;
    logic         r_is_write;
    logic         r_aw_held;
    logic         r_w_held;
    axil_addr_t   r_awaddr;
    axil_data_t   r_wdata;
    axil_strb_t   r_wstrb;

    logic         r_native_we;
    native_addr_t r_native_addr;
    axil_data_t   r_native_wdata;
    axil_strb_t   r_native_be;

    axil_resp_t   r_bresp;
    axil_resp_t   r_rresp;
    axil_data_t   r_rdata;

    logic         w_idle;
    logic         w_ar_ok;
    logic         w_ar_fire;
    logic         w_aw_rdy;
    logic         w_w_rdy;
    logic         w_aw_fire;
    logic         w_w_fire;
    logic         w_wr_go;
    logic         w_wr_misal;
    logic         w_rd_misal;
    logic         w_resp_done;
    axil_addr_t   w_wr_addr;
    axil_data_t   w_wr_data;
    axil_strb_t   w_wr_strb;

    // Readies stay low for one cycle after reset so nothing is accepted
    // while the block is still coming out of reset.
    assign w_idle    = (r_state == S_IDLE) && r_ready_en;
    assign w_ar_ok   = w_idle && !r_aw_held && !r_w_held &&
                       (r_prio_rd || (!awvalid_i && !wvalid_i));
    assign w_ar_fire = w_ar_ok && arvalid_i;
    assign w_aw_rdy  = w_idle && !r_aw_held && !w_ar_fire;
    assign w_w_rdy   = w_idle && !r_w_held && !w_ar_fire;
    assign w_aw_fire = w_aw_rdy && awvalid_i;
    assign w_w_fire  = w_w_rdy && wvalid_i;
    assign w_wr_go   = w_idle && (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);

    assign w_wr_addr  = r_aw_held ? r_awaddr : awaddr_i;
    assign w_wr_data  = r_w_held  ? r_wdata  : wdata_i;
    assign w_wr_strb  = r_w_held  ? r_wstrb  : wstrb_i;
    assign w_wr_misal = |w_wr_addr[1:0];
    assign w_rd_misal = |araddr_i[1:0];

    assign w_resp_done = ((r_state == S_BRESP) && bready_i) ||
                         ((r_state == S_RRESP) && rready_i);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr_go) begin
                    w_state_nxt = w_wr_misal ? S_BRESP : S_NREQ;
                end else if (w_ar_fire) begin
                    w_state_nxt = w_rd_misal ? S_RRESP : S_NREQ;
                end
            end
            S_NREQ: begin
                if (native_gnt_i) begin
                    w_state_nxt = S_NWAIT;
                end
            end
            S_NWAIT: begin
                if (native_rvalid_i) begin
                    w_state_nxt = r_is_write ? S_BRESP : S_RRESP;
                end
            end
            S_BRESP: begin
                if (bready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RRESP: begin
                if (rready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_ready_en     <= 1'b0;
            r_prio_rd      <= 1'b0;
            r_is_write     <= 1'b0;
            r_aw_held      <= 1'b0;
            r_w_held       <= 1'b0;
            r_awaddr       <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_native_we    <= 1'b0;
            r_native_addr  <= '0;
            r_native_wdata <= '0;
            r_native_be    <= '0;
            r_bresp        <= RESP_OKAY;
            r_rresp        <= RESP_OKAY;
            r_rdata        <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_en <= 1'b1;

            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= awaddr_i;
            end
            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata_i;
                r_wstrb  <= wstrb_i;
            end

            if (w_wr_go) begin
                r_is_write <= 1'b1;
                if (w_wr_misal) begin
                    r_bresp <= RESP_SLVERR;
                end else begin
                    r_native_we    <= 1'b1;
                    r_native_addr  <= axil2native_addr(w_wr_addr);
                    r_native_wdata <= w_wr_data;
                    r_native_be    <= w_wr_strb;
                end
            end else if (w_ar_fire) begin
                r_is_write <= 1'b0;
                if (w_rd_misal) begin
                    r_rresp <= RESP_SLVERR;
                    r_rdata <= '0;
                end else begin
                    r_native_we   <= 1'b0;
                    r_native_addr <= axil2native_addr(araddr_i);
                end
            end

            // Responses arriving in any other state are stray and dropped.
            if ((r_state == S_NWAIT) && native_rvalid_i) begin
                if (r_is_write) begin
                    r_bresp <= native_err_i ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    r_rresp <= native_err_i ? RESP_SLVERR : RESP_OKAY;
                    r_rdata <= native_err_i ? '0 : native_rdata_i;
                end
            end

            if (w_resp_done) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_prio_rd <= r_is_write;
            end
        end
    end

    assign awready_o      = w_aw_rdy;
    assign wready_o       = w_w_rdy;
    assign arready_o      = w_ar_ok;
    assign bvalid_o       = (r_state == S_BRESP);
    assign bresp_o        = r_bresp;
    assign rvalid_o       = (r_state == S_RRESP);
    assign rresp_o        = r_rresp;
    assign rdata_o        = r_rdata;
    assign native_req_o   = (r_state == S_NREQ);
    assign native_we_o    = r_native_we;
    assign native_addr_o  = r_native_addr;
    assign native_wdata_o = r_native_wdata;
    assign native_be_o    = r_native_be;

endmodule

`default_nettype wire

// File: doc/vga_axil_slave.md
# vga_axil_slave

AXI4-Lite slave front-end for the VGA register space: accepts AXI4-Lite read and write transactions and converts them into single word-addressed native register accesses, one at a time. Sits between the system interconnect (upstream) and the VGA register file/controller (downstream). Uses the shared AXI-Lite package types, widths and `axil2native_addr` conversion. Only OKAY and SLVERR responses are produced.

## Interface
- No parameters; all widths come from the package: ADDR 32, DATA 32, RESP 2, native address 30 bits (AXI address bits [31:2]).
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- awvalid_i / awready_o  in/out  1  write-address handshake; awaddr_i  in  32.
- wvalid_i / wready_o  in/out  1  write-data handshake; wdata_i  in  32; wstrb_i  in  4.
- bvalid_o / bready_i  out/in  1  write-response handshake; bresp_o  out  2.
- arvalid_i / arready_o  in/out  1  read-address handshake; araddr_i  in  32.
- rvalid_o / rready_i  out/in  1  read-data handshake; rdata_o  out  32; rresp_o  out  2.
- native_req_o  out  1  native access request, held until granted.
- native_we_o  out  1  1 = write, 0 = read.
- native_addr_o  out  30  word address = axil2native_addr(AXI address).
- native_wdata_o  out  32; native_be_o  out  4 (= captured wstrb).
- native_gnt_i  in  1  request accepted this cycle.
- native_rvalid_i  in  1  response strobe, one cycle, ≥1 cycle after gnt.
- native_rdata_i  in  32; native_err_i  in  1  (valid with native_rvalid_i).

## Operation
- States: IDLE, NREQ, NWAIT, BRESP, RRESP.
- IDLE: AW and W captured independently into holding regs (aw_held, w_held); awready_o = !aw_held, wready_o = !w_held. Read accepted (arready_o=1) only when no write beat held and (prio = read or awvalid_i=wvalid_i=0). When read accepted, awready_o/wready_o are 0 that cycle. Never accept read and write beats in the same cycle.
- Leave IDLE when address+data both held (write) or AR accepted (read).
- Alignment check: AXI address [1:0] ≠ 0 → no native access; go directly to BRESP/RRESP with SLVERR, rdata_o = 0.
- Aligned: NREQ drives native_req_o=1 with we/addr/wdata/be stable until native_gnt_i; then NWAIT.
- NWAIT: on native_rvalid_i go to BRESP (write) or RRESP (read); resp = native_err_i ? SLVERR(2'b10) : OKAY(2'b00); rdata_o = native_err_i ? 0 : native_rdata_i, registered.
- BRESP/RRESP: bvalid_o/rvalid_o held with stable resp/data until bready_i/rready_i; then clear holding regs, toggle prio to the other kind, return to IDLE.
- prio reset value = write. Wstrb 4'b0000 is still forwarded as a native write.
- native_rvalid_i outside NWAIT is ignored.

## Timing
- All outputs registered from state/holding regs; no combinational input→output paths except ready outputs (depend on awvalid_i/wvalid_i for arbitration).
- Reset: all valid/ready/req outputs 0 in the cycle after rst_i sampled high, then IDLE readies valid (awready_o=wready_o=1, arready_o=1 subject to arbitration); bresp_o/rresp_o = 2'b00, rdata_o = 0, native_* data outputs = 0; holding regs cleared; prio = write. Reset mid-transaction abandons it; no response issued.
- Aligned write, AW+W together at cycle 0, gnt at cycle 1, native_rvalid_i at cycle 2 → bvalid_o at cycle 3. Read same: rvalid_o at cycle 3.
- Misaligned: response valid 1 cycle after final address/data handshake.
- Back-to-back: after B/R handshake at cycle n, next beat accepted at cycle n+1.
- Only one transaction outstanding.

## Test plan
- Aligned write awaddr 0x0000_0010, wdata 0xDEAD_BEEF, wstrb 4'hF, gnt immediate, response ok → native_addr_o 0x4, we 1, be 4'hF; bresp_o 2'b00, bvalid_o 3 cycles after handshake.
- Aligned read araddr 0x0000_0008, native returns 0x1234_5678 after 4 cycles with gnt delayed 2 cycles → native_req_o held 3 cycles, native_addr_o 0x2; rdata_o 0x1234_5678, rresp_o 2'b00.
- Misaligned read 0x0000_0006 and write 0x0000_0001 → no native_req_o; rresp_o/bresp_o 2'b10, rdata_o 0.
- W arrives 3 cycles before AW; native_err_i=1 on response → single native write issued after AW; bresp_o 2'b10. Hold bready_i=0 for 5 cycles → bvalid_o/bresp_o stable, awready_o=0.
- AR, AW, W valid simultaneously out of reset → write served first, then read; next simultaneous pair → read first (alternation).
- rst_i asserted while in NWAIT → all outputs reset next cycle; late native_rvalid_i ignored; no bvalid_o/rvalid_o.
